psram_cmd_sched: RTL

//  Command sequencer and two-port arbiter for the PSRAM serial command engine.

---
 rtl/psram_cmd_sched.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/psram_cmd_sched.sv
// PSRAM command sequencer: power-up init (wait, RSTEN, RST, optional QPI entry) then
// round-robin arbitration of two requesters onto the serial command engine. Option macro: PSRAM_QPI_MODE_EN.
module psram_cmd_sched #(
    parameter int unsigned INIT_CYCLES = 12800,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter logic [7:0]  CMD_RSTEN   = 8'h66,
    parameter logic [7:0]  CMD_RST     = 8'h99,
    parameter logic [7:0]  CMD_QPI     = 8'h35
) (
    input  logic        mem_clk,
    input  logic        mem_rst_n,
    input  logic        startbu,
    output logic        init_done,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [22:0] req0_addr,
    output logic        req0_ready,
    output logic        req0_done,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [22:0] req1_addr,
    output logic        req1_ready,
    output logic        req1_done,
    output logic        grant,
    output logic        eng_valid,
    output logic [7:0]  eng_cmd,
    output logic [22:0] eng_addr,
    output logic        eng_has_addr,
    input  logic        eng_ready,
    input  logic        eng_done,
    output logic [3:0]  step
);

    typedef enum logic [3:0] {
        S_WAIT  = 4'd0,
        S_DELAY = 4'd1,
        S_RSTEN = 4'd2,
        S_RST   = 4'd3,
        S_QPI   = 4'd4,
        S_IDLE  = 4'd5,
        S_ISSUE = 4'd6,
        S_BUSY  = 4'd7,
        S_GAP   = 4'd8
    } state_t;

`ifdef PSRAM_QPI_MODE_EN
    localparam logic [7:0] CMD_READ  = 8'hEB;
    localparam logic [7:0] CMD_WRITE = 8'h38;
    localparam state_t     AFTER_RST = S_QPI;
`else
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam state_t     AFTER_RST = S_IDLE;
`endif

    localparam logic [15:0] TIMER_LAST = 16'(INIT_CYCLES - 1);
    localparam logic [3:0]  GAP_LAST   = 4'(GAP_CYCLES - 1);

    function automatic logic [7:0] init_opcode(input state_t s);
        case (s)
            S_RSTEN: init_opcode = CMD_RSTEN;
            S_RST:   init_opcode = CMD_RST;
            S_QPI:   init_opcode = CMD_QPI;
            default: init_opcode = 8'h00;
        endcase
    endfunction

    state_t      state;
    state_t      after_q;
    logic [15:0] timer;
    logic [3:0]  gap_cnt;
    logic        start_latch;
    logic        user_xfer;

    // Round-robin: on a tie the requester that did not own the last transfer wins.
    logic win0, win1, leave;
    assign win0  = req0_valid & (~req1_valid | grant);
    assign win1  = req1_valid & (~req0_valid | ~grant);
    assign leave = (state == S_BUSY && eng_done && GAP_CYCLES == 0) ||
                   (state == S_GAP && gap_cnt == GAP_LAST);
    assign step  = state;

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            state        <= S_WAIT;
            after_q      <= S_IDLE;
            timer        <= '0;
            gap_cnt      <= '0;
            start_latch  <= 1'b0;
            user_xfer    <= 1'b0;
            grant        <= 1'b1;
            init_done    <= 1'b0;
            req0_ready   <= 1'b0;
            req0_done    <= 1'b0;
            req1_ready   <= 1'b0;
            req1_done    <= 1'b0;
            eng_valid    <= 1'b0;
            eng_cmd      <= '0;
            eng_addr     <= '0;
            eng_has_addr <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_ready <= 1'b0;
            req1_done  <= 1'b0;
            case (state)
                S_WAIT: begin
                    start_latch <= start_latch | startbu;
                    if (startbu || start_latch) begin
                        state <= S_DELAY;
                        timer <= '0;
                    end
                end
                S_DELAY: begin
                    if (timer == TIMER_LAST) begin
                        timer        <= '0;
                        state        <= S_RSTEN;
                        eng_valid    <= 1'b1;
                        eng_cmd      <= CMD_RSTEN;
                        eng_has_addr <= 1'b0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_RSTEN, S_RST, S_QPI: begin
                    if (eng_valid && eng_ready) begin
                        eng_valid <= 1'b0;
                        user_xfer <= 1'b0;
                        state     <= S_BUSY;
                        case (state)
                            S_RSTEN: after_q <= S_RST;
                            S_RST:   after_q <= AFTER_RST;
                            default: after_q <= S_IDLE;
                        endcase
                    end
                end
                S_IDLE: begin
                    if (win0 || win1) begin
                        grant        <= win1;
                        eng_cmd      <= (win1 ? req1_we : req0_we) ? CMD_WRITE : CMD_READ;
                        eng_addr     <= win1 ? req1_addr : req0_addr;
                        eng_has_addr <= 1'b1;
                        eng_valid    <= 1'b1;
                        req0_ready   <= win0;
                        req1_ready   <= win1;
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (eng_valid && eng_ready) begin
                        eng_valid <= 1'b0;
                        user_xfer <= 1'b1;
                        after_q   <= S_IDLE;
                        state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (eng_done) begin
                        req0_done <= user_xfer & ~grant;
                        req1_done <= user_xfer & grant;
                        user_xfer <= 1'b0;
                        gap_cnt   <= '0;
                        if (GAP_CYCLES != 0)
                            state <= S_GAP;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                default: state <= S_WAIT;
            endcase

            // End of CE-high gap: enter the follow-on state with its command already presented.
            if (leave) begin
                state <= after_q;
                if (after_q == S_IDLE) begin
                    init_done <= 1'b1;
                end else begin
                    eng_valid    <= 1'b1;
                    eng_cmd      <= init_opcode(after_q);
                    eng_has_addr <= 1'b0;
                end
            end
        end
    end

endmodule
